// File: rtl/pulse_param_sync_pkg.sv
// Shared defaults for the pulse-generator parameter synchroniser: widths,
// channel indices and the power-on parameter set.
package pulse_param_sync_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_NUM_CH = 4;

  localparam int unsigned CH_TON  = 0;
  localparam int unsigned CH_TOFF = 1;
  localparam int unsigned CH_IP   = 2;
  localparam int unsigned CH_WAVE = 3;

  // Packed ch3..ch0; Toff powers up at 100 so the generator never runs with a zero off-time.
  localparam logic [DEF_NUM_CH*DEF_DATA_W-1:0] DEF_RESET_VALS =
    {16'h0000, 16'h0000, 16'd100, 16'd0};

endpackage

// File: rtl/pulse_param_sync_if.sv
// Request/data bundle between the async host side and the parameter synchroniser.
interface pulse_param_sync_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 16
);

  logic                       machine_start_ack;
  logic                       machine_stop_ack;
  logic [NUM_CH-1:0]          change_ack;
  logic [NUM_CH*DATA_W-1:0]   data_async;
  logic                       period_end;
  logic                       is_machine;
  logic [NUM_CH*DATA_W-1:0]   data_out;
  logic [NUM_CH-1:0]          pending;
  logic [NUM_CH-1:0]          updated;
  logic [NUM_CH-1:0]          overrun;

  modport master (
    output machine_start_ack, machine_stop_ack, change_ack, data_async, period_end,
    input  is_machine, data_out, pending, updated, overrun
  );

  modport slave (
    input  machine_start_ack, machine_stop_ack, change_ack, data_async, period_end,
    output is_machine, data_out, pending, updated, overrun
  );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one async level, plus a single-cycle rising-edge
// strobe taken from the last stage only.
module sync_edge_det #(
  parameter int unsigned STAGES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign level = r_sync[STAGES-1];
  assign rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/pulse_param_sync.sv
// Brings host parameter writes into the clk domain and, while machining, holds
// them in shadows until the pulse generator reaches a period boundary.
module pulse_param_sync
  import pulse_param_sync_pkg::*;
#(
  parameter int unsigned                    NUM_CH      = DEF_NUM_CH,
  parameter int unsigned                    DATA_W      = DEF_DATA_W,
  parameter int unsigned                    SYNC_STAGES = 3,
  parameter logic [NUM_CH*DATA_W-1:0]       RESET_VALS  = DEF_RESET_VALS,
  parameter bit                             COMMIT_MODE = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  pulse_param_sync_if.slave bus
);

  localparam int unsigned W = NUM_CH * DATA_W;

  logic              w_start_rise, w_stop_rise, w_start_level, w_stop_level;
  logic [NUM_CH-1:0] w_chg_rise, w_chg_level;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_start (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (bus.machine_start_ack),
    .level   (w_start_level),
    .rise    (w_start_rise)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_stop (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (bus.machine_stop_ack),
    .level   (w_stop_level),
    .rise    (w_stop_rise)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_chg (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_async (bus.change_ack[gi]),
      .level   (w_chg_level[gi]),
      .rise    (w_chg_rise[gi])
    );
  end

  // Only the edge strobes drive decisions; the levels are kept for observability.
  logic unused_levels;
  assign unused_levels = ^{w_start_level, w_stop_level, w_chg_level};

  logic              r_is_machine, w_is_machine_d;
  logic [W-1:0]      r_data_out, w_data_out_d;
  logic [W-1:0]      r_shadow, w_shadow_d;
  logic [NUM_CH-1:0] r_pending, w_pending_d;
  logic [NUM_CH-1:0] r_updated, w_updated_d;
  logic [NUM_CH-1:0] r_overrun, w_overrun_d;
  logic              w_flush, w_direct;

  always_comb begin
    w_is_machine_d = r_is_machine;
    if (w_stop_rise) begin
      w_is_machine_d = 1'b0;
    end else if (w_start_rise) begin
      w_is_machine_d = 1'b1;
    end

    // A stop edge drains shadows exactly like a period boundary does.
    w_flush  = bus.period_end | w_stop_rise;
    w_direct = !COMMIT_MODE | ~r_is_machine | w_flush;

    w_data_out_d = r_data_out;
    w_shadow_d   = r_shadow;
    w_pending_d  = r_pending;
    w_updated_d  = '0;
    w_overrun_d  = w_start_rise ? '0 : r_overrun;

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_chg_rise[i]) begin
        if (w_direct) begin
          w_data_out_d[i*DATA_W +: DATA_W] = bus.data_async[i*DATA_W +: DATA_W];
          w_pending_d[i] = 1'b0;
          w_updated_d[i] = 1'b1;
        end else begin
          w_shadow_d[i*DATA_W +: DATA_W] = bus.data_async[i*DATA_W +: DATA_W];
          w_pending_d[i] = 1'b1;
        end
        if (r_pending[i]) begin
          w_overrun_d[i] = 1'b1;
        end
      end else if (r_pending[i] && w_flush) begin
        w_data_out_d[i*DATA_W +: DATA_W] = r_shadow[i*DATA_W +: DATA_W];
        w_pending_d[i] = 1'b0;
        w_updated_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_is_machine <= 1'b0;
      r_data_out   <= RESET_VALS;
      r_shadow     <= RESET_VALS;
      r_pending    <= '0;
      r_updated    <= '0;
      r_overrun    <= '0;
    end else begin
      r_is_machine <= w_is_machine_d;
      r_data_out   <= w_data_out_d;
      r_shadow     <= w_shadow_d;
      r_pending    <= w_pending_d;
      r_updated    <= w_updated_d;
      r_overrun    <= w_overrun_d;
    end
  end

  assign bus.is_machine = r_is_machine;
  assign bus.data_out   = r_data_out;
  assign bus.pending    = r_pending;
  assign bus.updated    = r_updated;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_pulse_param_sync.sv
// Directed bench for pulse_param_sync with default parameters (3-stage sync,
// deferred commit); every expected value is a hand-computed constant.
module tb_pulse_param_sync;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   n_upd;

  pulse_param_sync_if #(.NUM_CH(4), .DATA_W(16)) bus ();

  pulse_param_sync dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int ch, input logic [15:0] val);
    bus.data_async[ch*16 +: 16] = val;
  endtask

  function automatic logic [15:0] word_of(input int ch);
    return bus.data_out[ch*16 +: 16];
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.machine_start_ack = 1'b0;
    bus.machine_stop_ack  = 1'b0;
    bus.change_ack        = '0;
    bus.data_async        = '0;
    bus.period_end        = 1'b0;

    // Reset
    tick(3);
    check_val("rst_data_out", bus.data_out, 64'h0000_0000_0064_0000);
    check_val("rst_is_machine", bus.is_machine, 0);
    check_val("rst_pending", bus.pending, 0);
    check_val("rst_updated", bus.updated, 0);
    check_val("rst_overrun", bus.overrun, 0);
    rst_n = 1'b1;
    tick(1);

    // Idle write: direct to data_out on edge 4, one updated pulse for a held level
    set_word(0, 16'h0032);
    bus.change_ack[0] = 1'b1;
    n_upd = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (bus.updated[0]) n_upd++;
      if (k == 2) check_val("idle_edge3_old", word_of(0), 16'h0000);
      if (k == 3) begin
        check_val("idle_edge4_new", word_of(0), 16'h0032);
        check_val("idle_upd_edge4", bus.updated, 4'b0001);
      end
    end
    check_val("idle_upd_count", n_upd, 1);
    bus.change_ack[0] = 1'b0;
    tick(4);

    // Start machining (level kept high: one action only)
    bus.machine_start_ack = 1'b1;
    tick(3);
    check_val("start_edge3", bus.is_machine, 0);
    tick(1);
    check_val("start_edge4", bus.is_machine, 1);

    // Deferred commit on ch1
    set_word(1, 16'd250);
    bus.change_ack[1] = 1'b1;
    tick(4);
    check_val("defer_pending", bus.pending, 4'b0010);
    check_val("defer_hold", word_of(1), 16'd100);
    tick(5);
    check_val("defer_still", bus.pending, 4'b0010);
    bus.period_end = 1'b1;
    tick(1);
    bus.period_end = 1'b0;
    check_val("defer_commit", word_of(1), 16'd250);
    check_val("defer_pend_clr", bus.pending, 0);
    check_val("defer_upd", bus.updated, 4'b0010);
    tick(1);
    check_val("defer_upd_1cyc", bus.updated, 0);
    bus.change_ack[1] = 1'b0;
    tick(4);

    // Atomic multi-channel commit
    set_word(0, 16'd40);
    set_word(2, 16'd7);
    bus.change_ack[0] = 1'b1;
    tick(2);
    bus.change_ack[2] = 1'b1;
    tick(6);
    check_val("atom_pending", bus.pending, 4'b0101);
    check_val("atom_hold0", word_of(0), 16'h0032);
    check_val("atom_hold2", word_of(2), 16'h0000);
    bus.period_end = 1'b1;
    tick(1);
    bus.period_end = 1'b0;
    check_val("atom_ch0", word_of(0), 16'd40);
    check_val("atom_ch2", word_of(2), 16'd7);
    check_val("atom_upd", bus.updated, 4'b0101);
    check_val("atom_pend_clr", bus.pending, 0);
    bus.change_ack = '0;
    tick(4);

    // Overrun on ch3: newest shadow wins
    set_word(3, 16'h0001);
    bus.change_ack[3] = 1'b1;
    tick(4);
    check_val("ovr_pend1", bus.pending, 4'b1000);
    check_val("ovr_none_yet", bus.overrun, 0);
    bus.change_ack[3] = 1'b0;
    tick(4);
    set_word(3, 16'h0002);
    bus.change_ack[3] = 1'b1;
    tick(4);
    check_val("ovr_flag", bus.overrun, 4'b1000);
    check_val("ovr_hold", word_of(3), 16'h0000);
    bus.period_end = 1'b1;
    tick(1);
    bus.period_end = 1'b0;
    check_val("ovr_commit", word_of(3), 16'h0002);
    check_val("ovr_sticky", bus.overrun, 4'b1000);
    bus.change_ack[3] = 1'b0;
    tick(4);

    // A fresh start edge clears overrun
    bus.machine_start_ack = 1'b0;
    tick(4);
    bus.machine_start_ack = 1'b1;
    tick(4);
    check_val("restart_ovr_clr", bus.overrun, 0);
    check_val("restart_machine", bus.is_machine, 1);

    // Stop while ch0 pending commits in the stop cycle
    set_word(0, 16'h0055);
    bus.change_ack[0] = 1'b1;
    tick(4);
    check_val("stop_pre_pend", bus.pending, 4'b0001);
    bus.change_ack[0] = 1'b0;
    bus.machine_stop_ack = 1'b1;
    tick(3);
    check_val("stop_edge3_pend", bus.pending, 4'b0001);
    tick(1);
    check_val("stop_machine", bus.is_machine, 0);
    check_val("stop_commit", word_of(0), 16'h0055);
    check_val("stop_pend_clr", bus.pending, 0);
    check_val("stop_upd", bus.updated, 4'b0001);

    // Start/stop collision: stop wins
    bus.machine_start_ack = 1'b0;
    bus.machine_stop_ack  = 1'b0;
    tick(4);
    bus.machine_start_ack = 1'b1;
    bus.machine_stop_ack  = 1'b1;
    tick(4);
    check_val("collide_edge", bus.is_machine, 0);
    tick(4);
    check_val("collide_after", bus.is_machine, 0);

    // Mid-operation reset discards shadows; held levels re-fire after release
    bus.machine_start_ack = 1'b0;
    bus.machine_stop_ack  = 1'b0;
    tick(4);
    bus.machine_start_ack = 1'b1;
    tick(4);
    check_val("mid_machine", bus.is_machine, 1);
    set_word(2, 16'd9);
    bus.change_ack[2] = 1'b1;
    tick(4);
    check_val("mid_pending", bus.pending, 4'b0100);
    rst_n = 1'b0;
    tick(1);
    check_val("mid_rst_pend", bus.pending, 0);
    check_val("mid_rst_data", bus.data_out, 64'h0000_0000_0064_0000);
    check_val("mid_rst_machine", bus.is_machine, 0);
    rst_n = 1'b1;
    tick(3);
    check_val("rel_edge3", bus.is_machine, 0);
    tick(1);
    check_val("rel_edge4_mach", bus.is_machine, 1);
    check_val("rel_edge4_ch2", word_of(2), 16'd9);
    check_val("rel_edge4_upd", bus.updated, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_param_sync.md
PULSE_PARAM_SYNC -- requirements
Module: pulse_param_sync

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  - NUM_CH, 4, number of parameter channels.
  - DATA_W, 16, width of each channel word.
  - SYNC_STAGES, 3, synchroniser depth; legal range 2..4.
  - RESET_VALS, {16'h0000,16'h0000,16'd100,16'd0} (ch3..ch0), per-channel reset value, NUM_CH*DATA_W bits.
  - COMMIT_MODE, 1; 0 = apply immediately, 1 = defer to pulse boundary while machining.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1, system clock.
  - rst_n, in, 1, reset: synchronous, active-low.
  - machine_start_ack, in, 1, async start request level.
  - machine_stop_ack, in, 1, async stop request level.
  - change_ack, in, NUM_CH, async per-channel change request level.
  - data_async, in, NUM_CH*DATA_W, async data; channel i at bits [i*DATA_W +: DATA_W].
  - period_end, in, 1, clk-domain single-cycle pulse from the pulse generator marking the end of a Ton/Toff period.
  - is_machine, out, 1, machining enabled.
  - data_out, out, NUM_CH*DATA_W, applied parameter words.
  - pending, out, NUM_CH, a shadow value is waiting for commit.
  - updated, out, NUM_CH, one-cycle pulse when data_out[i] changes source.
  - overrun, out, NUM_CH, sticky: a request arrived while the channel was pending.

Function
REQ-003 Every async level input SHALL pass through a SYNC_STAGES flop chain; decisions SHALL use only the last stage.
REQ-004 Each request SHALL be detected as a rising edge of the synchronised level: last stage high while the previous-cycle copy is low. A held-high level SHALL cause exactly one action.
REQ-005 A change request SHALL be detected on the (SYNC_STAGES+1)th clk edge after the input rises. On that edge, data_async channel i SHALL be captured, since data is stable before ack.
REQ-006 The captured word SHALL be written straight to data_out[i], with updated[i] pulsed on the next cycle, when any of these holds: COMMIT_MODE=0, is_machine=0, or period_end is high in the detect cycle.
REQ-007 Otherwise the captured word SHALL load shadow[i], set pending[i], and leave data_out[i] unchanged.
REQ-008 On a cycle with period_end=1, every pending channel SHALL copy shadow to data_out, clear pending, and pulse updated. All channels SHALL commit in the same cycle (atomic).
REQ-009 A detect on a channel already pending SHALL overwrite its shadow (newest wins), keep pending set, and set overrun[i].
REQ-010 overrun[i] SHALL clear only on reset or on a start edge.
REQ-011 is_machine SHALL be set by a start edge and cleared by a stop edge. If both edges occur in the same cycle, stop SHALL win and is_machine SHALL be 0.
REQ-012 When a stop edge clears is_machine, all pending shadows SHALL commit in that same cycle.
REQ-013 updated SHALL be a registered output, high for exactly one cycle per data_out write.

Reset
REQ-014 While rst_n=0 at a clk edge, the block SHALL reset: sync chains and edge copies 0, is_machine 0, data_out and shadow = RESET_VALS, pending 0, updated 0, overrun 0.
REQ-015 Reset asserted mid-operation SHALL discard all pending shadows. Input levels already high when rst_n releases SHALL produce one edge after SYNC_STAGES+1 cycles.

Structure
REQ-016 A shared package SHALL hold the default DATA_W, NUM_CH, channel index constants (CH_TON=0, CH_TOFF=1, CH_IP=2, CH_WAVE=3) and the default RESET_VALS.
REQ-017 One sub-module, sync_edge_det (parameter STAGES; ports clk, rst_n, d_async, level, rise), SHALL be instantiated NUM_CH+2 times.

Verification
REQ-018 The bench SHALL cover these directed scenarios (stimulus -> required response):
  - Reset: rst_n=0 for 3 clk -> data_out ch1=100, all other channels 0; is_machine=0; pending=0.
  - Idle write: is_machine=0, data_async ch0=16'h0032, change_ack[0] rises and is held 20 cycles -> data_out ch0=16'h0032 on edge 4 (SYNC_STAGES=3); exactly one updated[0] pulse.
  - Deferred commit: is_machine=1, ch1 write 16'd250 -> pending[1]=1 and data_out unchanged; then period_end pulse -> data_out ch1=250, pending=0, updated[1] pulse.
  - Atomic multi-channel: is_machine=1, ch0=40 and ch2=7 pending -> both applied on the same period_end cycle.
  - Overrun: is_machine=1, ch3 writes 16'h0001 then 16'h0002 before period_end -> overrun[3]=1; commit yields 16'h0002.
  - Start/stop collision: start and stop rise together -> is_machine stays 0; a stop while ch0 is pending -> commit in the same cycle.
